program_counter: RTL and testbench

4-bit program counter for the SAP-1 datapath, built as a synchronous binary counter whose stages are the team's JK toggle flip-flops. It holds the address of the next instruction and drives it onto the W bus during the fetch T-state. It also supports a parallel load from the W bus for jump instructions. Downstream, the W bus feeds the memory address register. Upstream, the controller-sequencer supplies the CP, EP and LP strobes.

---
 rtl/program_counter.sv | 78 +++++++
 tb/tb_program_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// SAP-1 program counter: synchronous binary counter built from JK toggle
// stages, with parallel load from the W bus and a tri-state W bus drive.

// Single JK flip-flop stage, updating on the falling edge of the clock.
module pc_jk_ff (
  input  logic i_clk_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  // JK next state: J=1,K=0 sets, J=0,K=1 clears, J=K=1 toggles, J=K=0 holds
  always_ff @(negedge i_clk_n) begin
    r_q <= (i_j & ~r_q) | (~i_k & r_q);
  end

  assign o_q = r_q;

endmodule

module program_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK_N,
  input  logic             CLR,
  input  logic             CP,
  input  logic             EP,
  input  logic             LP,
  input  logic [WIDTH-1:0] D_IN,
  output wire  [WIDTH-1:0] W_BUS,
  output logic [WIDTH-1:0] PC_Q,
  output logic             TC
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  // Stage i toggles when counting and every lower stage is at 1 (ripple-free carry)
  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_toggle
    if (gi == 0) begin : g_lsb
      assign w_toggle[gi] = CP;
    end else begin : g_upper
      assign w_toggle[gi] = CP & (&w_q[gi-1:0]);
    end
  end

  // Stage input muxing: clear forces K, load presents D_IN as set/clear, else toggle
  always_comb begin
    w_j = w_toggle;
    w_k = w_toggle;
    if (CLR) begin
      w_j = '0;
      w_k = '1;
    end else if (LP) begin
      w_j = D_IN;
      w_k = ~D_IN;
    end
  end

  // One JK flip-flop per counter bit
  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_stage
    pc_jk_ff u_stage (
      .i_clk_n (CLK_N),
      .i_j     (w_j[gi]),
      .i_k     (w_k[gi]),
      .o_q     (w_q[gi])
    );
  end

  assign PC_Q  = w_q;
  assign TC    = &w_q;
  assign W_BUS = EP ? w_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vector table, hand-written
// corner sequences, and randomized strobes checked against an arithmetic model.
// The W bus is weakly pulled up, so an undriven bus reads as all ones.
module tb_program_counter;

  localparam int unsigned W = 4;

  logic         clk_n;
  logic         clr;
  logic         cp;
  logic         ep;
  logic         lp;
  logic [W-1:0] d_in;
  wire  [W-1:0] w_bus;
  logic [W-1:0] pc_q;
  logic         tc;

  int total;
  int bad;

  pullup (w_bus[0]);
  pullup (w_bus[1]);
  pullup (w_bus[2]);
  pullup (w_bus[3]);

  program_counter #(.WIDTH(W)) dut (
    .CLK_N (clk_n),
    .CLR   (clr),
    .CP    (cp),
    .EP    (ep),
    .LP    (lp),
    .D_IN  (d_in),
    .W_BUS (w_bus),
    .PC_Q  (pc_q),
    .TC    (tc)
  );

  initial clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  typedef struct {
    logic         clr;
    logic         cp;
    logic         lp;
    logic         ep;
    logic [W-1:0] d;
    logic [W-1:0] exp_pc;
    logic         exp_tc;
  } vec_t;

  vec_t vecs[$];

  // Expected model state (plain arithmetic)
  int model_pc;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] bus_expect(input logic e, input int pc);
    return e ? W'(pc) : {W{1'b1}};
  endfunction

  task automatic add_vec(input logic c, input logic p, input logic l, input logic e,
                         input logic [W-1:0] d, input logic [W-1:0] epc, input logic etc);
    vec_t v;
    v.clr = c; v.cp = p; v.lp = l; v.ep = e; v.d = d; v.exp_pc = epc; v.exp_tc = etc;
    vecs.push_back(v);
  endtask

  // Drive strobes mid-cycle, let one falling edge pass, sample just after it
  task automatic apply(input logic c, input logic p, input logic l, input logic e,
                       input logic [W-1:0] d);
    @(posedge clk_n);
    clr = c; cp = p; lp = l; ep = e; d_in = d;
    @(negedge clk_n);
    #1;
  endtask

  function automatic int model_next(input logic c, input logic p, input logic l,
                                    input logic [W-1:0] d, input int pc);
    if (c) return 0;
    if (l) return int'(d);
    if (p) return (pc + 1) % (1 << W);
    return pc;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    clr = 1'b0; cp = 1'b0; lp = 1'b0; ep = 1'b0; d_in = '0;

    // Directed vector table following the basic sequence
    add_vec(1, 1, 1, 0, 4'h9, 4'h0, 0);
    for (int i = 1; i <= 15; i++) add_vec(0, 1, 0, (i == 3), 4'h0, W'(i), (i == 15));
    add_vec(0, 1, 0, 0, 4'h0, 4'h0, 0);
    add_vec(0, 1, 1, 1, 4'hA, 4'hA, 0);
    add_vec(0, 1, 0, 0, 4'h0, 4'hB, 0);
    add_vec(0, 1, 0, 1, 4'h0, 4'hC, 0);
    add_vec(0, 0, 1, 0, 4'h5, 4'h5, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 0, (i == 1), 4'h0, 4'h5, 0);
    add_vec(0, 0, 1, 0, 4'h6, 4'h6, 0);
    add_vec(0, 1, 0, 0, 4'h0, 4'h7, 0);
    add_vec(1, 1, 0, 0, 4'h0, 4'h0, 0);
    add_vec(0, 1, 0, 0, 4'h0, 4'h1, 0);
    add_vec(0, 0, 1, 0, 4'hF, 4'hF, 1);
    add_vec(1, 0, 1, 1, 4'h3, 4'h0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].clr, vecs[i].cp, vecs[i].lp, vecs[i].ep, vecs[i].d);
      check($sformatf("vec%0d_pc", i), pc_q, vecs[i].exp_pc);
      check($sformatf("vec%0d_tc", i), W'(tc), W'(vecs[i].exp_tc));
      check($sformatf("vec%0d_bus", i), w_bus, bus_expect(vecs[i].ep, int'(vecs[i].exp_pc)));
    end

    // Bus drive at PC=3: follows EP within the same cycle and holds across a non-changing edge
    apply(0, 0, 1, 0, 4'h3);
    check("bus_idle", w_bus, 4'hF);
    @(posedge clk_n);
    ep = 1'b1; lp = 1'b0;
    #1;
    check("bus_same_cycle", w_bus, 4'h3);
    @(negedge clk_n);
    #1;
    check("bus_after_hold_edge", w_bus, 4'h3);
    ep = 1'b0;
    #1;
    check("bus_release", w_bus, 4'hF);

    // Short CP pulse lying entirely between falling edges is ignored
    @(posedge clk_n);
    #1 cp = 1'b1;
    #1 cp = 1'b0;
    @(negedge clk_n);
    #1;
    check("glitch_pc", pc_q, 4'h3);

    // Randomized strobes against the model
    model_pc = 3;
    for (int n = 0; n < 300; n++) begin
      logic c, p, l, e;
      logic [W-1:0] d;
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 3) != 0);
      e = $urandom_range(0, 1) == 1;
      d = W'($urandom_range(0, 15));
      apply(c, p, l, e, d);
      model_pc = model_next(c, p, l, d, model_pc);
      check("rand_pc", pc_q, W'(model_pc));
      check("rand_tc", W'(tc), W'(model_pc == (1 << W) - 1));
      check("rand_bus", w_bus, bus_expect(e, model_pc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
